// File: rtl/key_message_buffer.sv
// key_message_buffer
// Collects keyboard characters into a fixed-size message and hands the
// closed message to a consumer with a valid/ready handshake.
//
// Optional feature macro: KMB_BACKSPACE_EN (DEL = 127 erases the last char).
//
// Ports:
//   clock      - single clock, rising edge
//   RESETN     - asynchronous active-low reset
//   key_valid  - one-cycle strobe, new character on key_char
//   key_char   - character value (0 is ignored)
//   send_req   - one-cycle strobe, close a non-empty message early
//   msg_ready  - consumer accepts the held message
//   msg_valid  - a closed message is being held
//   message    - slot 0 in the MSBs, unused slots zero
//   msg_len    - number of characters stored
//   full       - msg_len == DEPTH
//   drop_cnt   - saturating count of discarded characters
module key_message_buffer #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CHAR_W = 8,
    parameter int unsigned CNT_W  = 5
) (
    input  logic                      clock,
    input  logic                      RESETN,
    input  logic                      key_valid,
    input  logic [CHAR_W-1:0]         key_char,
    input  logic                      send_req,
    input  logic                      msg_ready,
    output logic                      msg_valid,
    output logic [DEPTH*CHAR_W-1:0]   message,
    output logic [CNT_W-1:0]          msg_len,
    output logic                      full,
    output logic [7:0]                drop_cnt
);

    localparam int unsigned      MSG_W   = DEPTH * CHAR_W;
    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(DEPTH);
`ifdef KMB_BACKSPACE_EN
    localparam logic [CHAR_W-1:0] DEL_CHAR = CHAR_W'(127);
`endif

    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [MSG_W-1:0]   msg_q, msg_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic               full_q, full_d;
    logic [7:0]         drop_q, drop_d;
    logic               char_live;

    // State and datapath registers
    always_ff @(posedge clock or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= COLLECT;
            msg_q   <= '0;
            len_q   <= '0;
            full_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            len_q   <= len_d;
            full_q  <= full_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        msg_d     = msg_q;
        len_d     = len_q;
        drop_d    = drop_q;
        char_live = key_valid && (key_char != '0);

        case (state_q)
            COLLECT: begin
                if (char_live) begin
`ifdef KMB_BACKSPACE_EN
                    if (key_char == DEL_CHAR) begin
                        if (len_q != '0) begin
                            len_d = len_q - CNT_W'(1);
                            for (int i = 0; i < DEPTH; i++) begin
                                if (CNT_W'(i) == len_d)
                                    msg_d[(DEPTH-1-i)*CHAR_W +: CHAR_W] = '0;
                            end
                        end
                    end else
`endif
                    begin
                        for (int i = 0; i < DEPTH; i++) begin
                            if (CNT_W'(i) == len_q)
                                msg_d[(DEPTH-1-i)*CHAR_W +: CHAR_W] = key_char;
                        end
                        len_d = len_q + CNT_W'(1);
                    end
                end
                // Close on reaching capacity, or on request once the (post-write) length is non-zero
                if (len_d == LEN_MAX)
                    state_d = HOLD;
                else if (send_req && (len_d != '0))
                    state_d = HOLD;
            end
            HOLD: begin
                // Any character while holding (including one coinciding with a transfer) is dropped
                if (char_live && (drop_q != 8'hFF))
                    drop_d = drop_q + 8'd1;
                if (msg_ready) begin
                    msg_d   = '0;
                    len_d   = '0;
                    state_d = COLLECT;
                end
            end
        endcase

        full_d = (len_d == LEN_MAX);
    end

    assign msg_valid = (state_q == HOLD);
    assign message   = msg_q;
    assign msg_len   = len_q;
    assign full      = full_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_key_message_buffer.sv
module tb_key_message_buffer;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned CHAR_W = 8;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned MW     = DEPTH * CHAR_W;

    logic              clock;
    logic              RESETN;
    logic              key_valid;
    logic [CHAR_W-1:0] key_char;
    logic              send_req;
    logic              msg_ready;
    logic              msg_valid;
    logic [MW-1:0]     message;
    logic [CNT_W-1:0]  msg_len;
    logic              full;
    logic [7:0]        drop_cnt;

    int n_vec;
    int n_err;

    key_message_buffer #(.DEPTH(DEPTH), .CHAR_W(CHAR_W), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .RESETN    (RESETN),
        .key_valid (key_valid),
        .key_char  (key_char),
        .send_req  (send_req),
        .msg_ready (msg_ready),
        .msg_valid (msg_valid),
        .message   (message),
        .msg_len   (msg_len),
        .full      (full),
        .drop_cnt  (drop_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        kv;
        logic [7:0]  kc;
        logic        sr;
        logic        mr;
        logic        ev;
        logic [4:0]  el;
        logic        ef;
        logic [7:0]  ed;
        logic [15:0] etop;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic kv, input logic [7:0] kc, input logic sr, input logic mr);
        @(negedge clock);
        key_valid = kv;
        key_char  = kc;
        send_req  = sr;
        msg_ready = mr;
        @(posedge clock);
        #1;
        key_valid = 1'b0;
        key_char  = '0;
        send_req  = 1'b0;
        msg_ready = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_valid"}, MW'(msg_valid), '0);
        chk({nm, "_msg"},   message,        '0);
        chk({nm, "_len"},   MW'(msg_len),   '0);
        chk({nm, "_full"},  MW'(full),      '0);
        chk({nm, "_drop"},  MW'(drop_cnt),  '0);
    endtask

    task automatic do_reset();
        #2 RESETN = 1'b0;
        #1;
        @(negedge clock);
        @(negedge clock);
        RESETN = 1'b1;
    endtask

    logic [MW-1:0] exp_msg;

    initial begin
        n_vec     = 0;
        n_err     = 0;
        RESETN    = 1'b1;
        key_valid = 1'b0;
        key_char  = '0;
        send_req  = 1'b0;
        msg_ready = 1'b0;

        //            kv  kc     sr  mr  ev  len ef  drop etop
        vt[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 8'd0, 16'h0000};
        vt[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 8'd0, 16'h0000};
        vt[2]  = '{1'b1, 8'h68, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 8'd0, 16'h6800};
        vt[3]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 8'd0, 16'h6800};
        vt[4]  = '{1'b1, 8'h69, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 8'd0, 16'h6869};
        vt[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd2, 1'b0, 8'd0, 16'h6869};
        vt[6]  = '{1'b1, 8'h78, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, 8'd1, 16'h6869};
        vt[7]  = '{1'b1, 8'h79, 1'b1, 1'b0, 1'b1, 5'd2, 1'b0, 8'd2, 16'h6869};
        vt[8]  = '{1'b1, 8'h7a, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, 8'd3, 16'h6869};
        vt[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'd3, 16'h0000};
        vt[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'd3, 16'h0000};
        vt[11] = '{1'b1, 8'h71, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 8'd3, 16'h7100};
        vt[12] = '{1'b1, 8'h72, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'd4, 16'h0000};

        // Asynchronous reset with no clock edge needed
        #2 RESETN = 1'b0;
        #1;
        chk_all_zero("por");
        @(negedge clock);
        @(negedge clock);
        RESETN = 1'b1;

        // Table-driven single-cycle vectors
        for (int v = 0; v < 13; v++) begin
            step(vt[v].kv, vt[v].kc, vt[v].sr, vt[v].mr);
            chk($sformatf("v%0d_valid", v), MW'(msg_valid), MW'(vt[v].ev));
            chk($sformatf("v%0d_len", v),   MW'(msg_len),   MW'(vt[v].el));
            chk($sformatf("v%0d_full", v),  MW'(full),      MW'(vt[v].ef));
            chk($sformatf("v%0d_drop", v),  MW'(drop_cnt),  MW'(vt[v].ed));
            chk($sformatf("v%0d_top", v),   MW'(message[MW-1 -: 16]), MW'(vt[v].etop));
            chk($sformatf("v%0d_rest", v),  MW'(message[MW-17:0]),    '0);
        end

        // Fill to capacity with "a".."p"
        exp_msg = '0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(8'h61 + i), 1'b0, 1'b0);
            exp_msg[(15-i)*8 +: 8] = 8'(8'h61 + i);
            if (i == 14) begin
                chk("fill15_valid", MW'(msg_valid), '0);
                chk("fill15_full",  MW'(full),      '0);
                chk("fill15_len",   MW'(msg_len),   MW'(15));
            end
        end
        chk("fill_valid", MW'(msg_valid), MW'(1));
        chk("fill_full",  MW'(full),      MW'(1));
        chk("fill_len",   MW'(msg_len),   MW'(16));
        chk("fill_msg",   message,        exp_msg);
        chk("fill_msg_k", message,        128'h6162636465666768696a6b6c6d6e6f70);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("xfer_valid", MW'(msg_valid), '0);
        chk("xfer_full",  MW'(full),      '0);
        chk("xfer_len",   MW'(msg_len),   '0);
        chk("xfer_msg",   message,        '0);

`ifdef KMB_BACKSPACE_EN
        step(1'b1, 8'h7f, 1'b0, 1'b0);
        chk("del_empty_len", MW'(msg_len), '0);
        step(1'b1, 8'h61, 1'b0, 1'b0);
        step(1'b1, 8'h62, 1'b0, 1'b0);
        step(1'b1, 8'h7f, 1'b0, 1'b0);
        chk("del_len", MW'(msg_len), MW'(1));
        chk("del_top", MW'(message[MW-1 -: 16]), MW'(16'h6100));
        step(1'b1, 8'h63, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("bs_valid", MW'(msg_valid), MW'(1));
        chk("bs_top",   MW'(message[MW-1 -: 16]), MW'(16'h6163));
        chk("bs_len",   MW'(msg_len), MW'(2));
        step(1'b1, 8'h7f, 1'b0, 1'b0);
        chk("bs_hold_drop", MW'(drop_cnt), MW'(5));
        chk("bs_hold_len",  MW'(msg_len),  MW'(2));
        step(1'b0, 8'h00, 1'b0, 1'b1);
`else
        step(1'b1, 8'h7f, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("del_ord_valid", MW'(msg_valid), MW'(1));
        chk("del_ord_len",   MW'(msg_len),   MW'(1));
        chk("del_ord_top",   MW'(message[MW-1 -: 16]), MW'(16'h7f00));
        step(1'b0, 8'h00, 1'b0, 1'b1);
`endif

        // Reset mid-message: everything clears immediately, no valid pulse
        step(1'b1, 8'h78, 1'b0, 1'b0);
        chk("xyz1_valid", MW'(msg_valid), '0);
        step(1'b1, 8'h79, 1'b0, 1'b0);
        chk("xyz2_valid", MW'(msg_valid), '0);
        step(1'b1, 8'h7a, 1'b0, 1'b0);
        chk("xyz3_valid", MW'(msg_valid), '0);
        chk("xyz3_len",   MW'(msg_len),   MW'(3));
        #2 RESETN = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        @(posedge clock);
        #1;
        chk_all_zero("rst_held");
        @(negedge clock);
        RESETN = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk_all_zero("rst_rel");

        // Reset mid-HOLD discards the message
        step(1'b1, 8'h61, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("hold_pre_valid", MW'(msg_valid), MW'(1));
        do_reset();
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk_all_zero("rst_hold");

        // Drop counter saturation
        step(1'b1, 8'h61, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b0);
        chk("null_drop", MW'(drop_cnt), '0);
        for (int i = 0; i < 254; i++) step(1'b1, 8'h41, 1'b0, 1'b0);
        chk("drop254", MW'(drop_cnt), MW'(254));
        for (int i = 0; i < 46; i++) step(1'b1, 8'h41, 1'b0, 1'b0);
        chk("drop_sat", MW'(drop_cnt), MW'(255));
        chk("drop_sat_len", MW'(msg_len), MW'(1));
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("sat_xfer_valid", MW'(msg_valid), '0);
        chk("sat_xfer_drop",  MW'(drop_cnt),  MW'(255));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
